// File: rtl/traf_ctrl_param_if.sv
// Detector/mode inputs and lamp/status outputs of the traffic-light controller.
interface traf_ctrl_param_if;
  logic       req_sgn;
  logic       flash_en;
  logic [5:0] led;
  logic [2:0] state_o;
  logic       req_pend;

  modport master (
    output req_sgn, flash_en,
    input  led, state_o, req_pend
  );

  modport slave (
    input  req_sgn, flash_en,
    output led, state_o, req_pend
  );
endinterface

// File: rtl/traf_ctrl_param.sv
// Two-road traffic-light controller with main-road priority, all-red clearance,
// latched country request and a night/fault flashing mode.
module traf_ctrl_param #(
  parameter int unsigned      CNT_W    = 32,
  parameter logic [CNT_W-1:0] T_MG     = CNT_W'(64'd3_000_000_000),
  parameter logic [CNT_W-1:0] T_Y      = CNT_W'(64'd200_000_000),
  parameter logic [CNT_W-1:0] T_AR     = CNT_W'(64'd100_000_000),
  parameter logic [CNT_W-1:0] T_CG_MIN = CNT_W'(64'd300_000_000),
  parameter logic [CNT_W-1:0] T_CG_MAX = CNT_W'(64'd1_000_000_000),
  parameter logic [CNT_W-1:0] T_BLINK  = CNT_W'(64'd50_000_000)
) (
  input logic              clk,
  input logic              rst,
  traf_ctrl_param_if.slave bus
);

  typedef enum logic [2:0] {
    S_MG    = 3'd0,
    S_MY    = 3'd1,
    S_AR1   = 3'd2,
    S_CG    = 3'd3,
    S_CY    = 3'd4,
    S_AR2   = 3'd5,
    S_FLASH = 3'd6
  } state_e;

  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
  localparam logic [CNT_W-1:0] MG_LAST     = T_MG - ONE;
  localparam logic [CNT_W-1:0] Y_LAST      = T_Y - ONE;
  localparam logic [CNT_W-1:0] AR_LAST     = T_AR - ONE;
  localparam logic [CNT_W-1:0] CG_MIN_LAST = T_CG_MIN - ONE;
  localparam logic [CNT_W-1:0] CG_MAX_LAST = T_CG_MAX - ONE;
  localparam logic [CNT_W-1:0] BLINK_LAST  = T_BLINK - ONE;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       led_q, led_d;
  logic             req_pend_q, req_pend_d;
  logic             blink_q, blink_d;
  logic             chg;
  logic             blink_wrap;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_MG:    if (bus.flash_en || (cnt_q >= MG_LAST && req_pend_q)) state_d = S_MY;
      S_MY:    if (cnt_q == Y_LAST) state_d = S_AR1;
      S_AR1:   if (cnt_q == AR_LAST) state_d = bus.flash_en ? S_FLASH : S_CG;
      S_CG:    if (bus.flash_en || cnt_q == CG_MAX_LAST ||
                   (cnt_q >= CG_MIN_LAST && !bus.req_sgn)) state_d = S_CY;
      S_CY:    if (cnt_q == Y_LAST) state_d = S_AR2;
      S_AR2:   if (cnt_q == AR_LAST) state_d = bus.flash_en ? S_FLASH : S_MG;
      S_FLASH: if (!bus.flash_en) state_d = S_AR2;
      default: state_d = S_AR2;
    endcase

    chg        = (state_d != state_q);
    blink_wrap = (state_q == S_FLASH) && (cnt_q == BLINK_LAST);

    // In FLASH the dwell counter doubles as the blink half-period timer.
    if (chg || blink_wrap)  cnt_d = '0;
    else if (cnt_q != '1)   cnt_d = cnt_q + ONE;
    else                    cnt_d = cnt_q;

    if (chg)             blink_d = 1'b0;
    else if (blink_wrap) blink_d = ~blink_q;
    else                 blink_d = blink_q;

    if (chg && (state_d == S_CG || state_d == S_FLASH))
      req_pend_d = 1'b0;
    else if (bus.req_sgn && state_q != S_CG && state_q != S_FLASH)
      req_pend_d = 1'b1;
    else
      req_pend_d = req_pend_q;

    // Lamps decoded from the next state so led and state_o change on the same edge.
    case (state_d)
      S_MG:    led_d = 6'b001_100;
      S_MY:    led_d = 6'b010_100;
      S_CG:    led_d = 6'b100_001;
      S_CY:    led_d = 6'b100_010;
      S_FLASH: led_d = blink_d ? 6'b000_000 : 6'b010_100;
      default: led_d = 6'b100_100;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_AR2;
      cnt_q      <= '0;
      led_q      <= 6'b100_100;
      req_pend_q <= 1'b0;
      blink_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      led_q      <= led_d;
      req_pend_q <= req_pend_d;
      blink_q    <= blink_d;
    end
  end

  assign bus.led      = led_q;
  assign bus.state_o  = state_q;
  assign bus.req_pend = req_pend_q;

  // Never a green or yellow on both roads at once.
  a_no_conflict: assert property (@(posedge clk)
    !((led_q[4] || led_q[3]) && (led_q[1] || led_q[0])));

endmodule

// File: tb/tb_traf_ctrl_param.sv
// Directed scenarios plus randomized traffic for traf_ctrl_param, checked each
// cycle against a phase/age reference model.
module tb_traf_ctrl_param;

  localparam int CW     = 8;
  localparam int TMG    = 10;
  localparam int TY     = 3;
  localparam int TAR    = 2;
  localparam int TCGMIN = 4;
  localparam int TCGMAX = 8;
  localparam int TBL    = 2;
  localparam int BOUND  = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  traf_ctrl_param_if bus();

  traf_ctrl_param #(
    .CNT_W   (CW),
    .T_MG    (8'(TMG)),
    .T_Y     (8'(TY)),
    .T_AR    (8'(TAR)),
    .T_CG_MIN(8'(TCGMIN)),
    .T_CG_MAX(8'(TCGMAX)),
    .T_BLINK (8'(TBL))
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase number 0..6 and age = cycles spent in the phase.
  int m_ph   = 5;
  int m_age  = 0;
  bit m_pend = 1'b0;

  function automatic logic [5:0] m_led();
    case (m_ph)
      0:       return 6'b001_100;
      1:       return 6'b010_100;
      3:       return 6'b100_001;
      4:       return 6'b100_010;
      6:       return ((m_age / TBL) % 2 == 0) ? 6'b010_100 : 6'b000_000;
      default: return 6'b100_100;
    endcase
  endfunction

  task automatic m_step(input logic r, input logic req, input logic fl);
    int np;
    if (r) begin
      m_ph = 5; m_age = 0; m_pend = 1'b0;
      return;
    end
    np = m_ph;
    case (m_ph)
      0: if (fl || (m_age + 1 >= TMG && m_pend)) np = 1;
      1: if (m_age + 1 == TY) np = 2;
      2: if (m_age + 1 == TAR) np = fl ? 6 : 3;
      3: if (fl || m_age + 1 == TCGMAX || (m_age + 1 >= TCGMIN && !req)) np = 4;
      4: if (m_age + 1 == TY) np = 5;
      5: if (m_age + 1 == TAR) np = fl ? 6 : 0;
      default: if (!fl) np = 5;
    endcase
    if (np != m_ph && (np == 3 || np == 6)) m_pend = 1'b0;
    else if (req && m_ph != 3 && m_ph != 6) m_pend = 1'b1;
    m_age = (np != m_ph) ? 0 : m_age + 1;
    m_ph  = np;
  endtask

  always @(posedge clk) begin
    m_step(rst, bus.req_sgn, bus.flash_en);
    #1;
    check("model state_o", 32'(bus.state_o), 32'(m_ph));
    check("model led", 32'(bus.led), 32'(m_led()));
    check("model req_pend", 32'(bus.req_pend), 32'(m_pend));
  end

  task automatic wait_state(input string nm, input logic [2:0] st, output int n);
    n = 0;
    while (bus.state_o !== st && n < BOUND) begin
      n++;
      @(negedge clk);
    end
    check({nm, " reached"}, 32'(bus.state_o), 32'(st));
  endtask

  // Called on the first visible cycle of a phase; returns on the first cycle of the next.
  task automatic expect_phase(input string nm, input logic [2:0] st, input logic [5:0] ld,
                              input int len);
    int n = 0;
    check({nm, " state"}, 32'(bus.state_o), 32'(st));
    check({nm, " led"}, 32'(bus.led), 32'(ld));
    while (bus.state_o === st && n < BOUND) begin
      n++;
      @(negedge clk);
    end
    check({nm, " length"}, 32'(n), 32'(len));
  endtask

  initial begin
    int n;
    bus.req_sgn  = 1'b0;
    bus.flash_en = 1'b0;
    rst          = 1'b1;
    repeat (3) @(negedge clk);

    // 1: reset state, AR2 for T_AR, then MG held long enough to saturate cnt
    rst = 1'b0;
    check("rst state_o", 32'(bus.state_o), 32'd5);
    check("rst led", 32'(bus.led), 32'h24);
    check("rst req_pend", 32'(bus.req_pend), 32'd0);
    @(negedge clk);
    check("s1 ar2 led", 32'(bus.led), 32'h24);
    @(negedge clk);
    check("s1 mg led", 32'(bus.led), 32'h0c);
    check("s1 mg state", 32'(bus.state_o), 32'd0);
    repeat (258) @(negedge clk);
    check("s1 mg held", 32'(bus.led), 32'h0c);

    // 2: continuous request; a wrapped counter would delay this exit
    bus.req_sgn = 1'b1;
    wait_state("s2 sat exit", 3'd1, n);
    check("s2 sat exit cycles", 32'(n), 32'd2);
    expect_phase("s2 MY", 3'd1, 6'b010_100, TY);
    expect_phase("s2 AR1", 3'd2, 6'b100_100, TAR);
    check("s2 CG pend", 32'(bus.req_pend), 32'd0);
    expect_phase("s2 CG", 3'd3, 6'b100_001, TCGMAX);
    check("s2 CY pend", 32'(bus.req_pend), 32'd0);
    expect_phase("s2 CY", 3'd4, 6'b100_010, TY);
    check("s2 AR2 pend", 32'(bus.req_pend), 32'd1);
    expect_phase("s2 AR2", 3'd5, 6'b100_100, TAR);
    expect_phase("s2 MG", 3'd0, 6'b001_100, TMG);
    bus.req_sgn = 1'b0;
    expect_phase("s2b MY", 3'd1, 6'b010_100, TY);
    expect_phase("s2b AR1", 3'd2, 6'b100_100, TAR);
    expect_phase("s2b CG gapout", 3'd3, 6'b100_001, TCGMIN);
    expect_phase("s2b CY", 3'd4, 6'b100_010, TY);
    expect_phase("s2b AR2", 3'd5, 6'b100_100, TAR);

    // 3: single-cycle request pulse at MG cycle 3
    check("s3 MG pend", 32'(bus.req_pend), 32'd0);
    repeat (3) @(negedge clk);
    bus.req_sgn = 1'b1;
    @(negedge clk);
    bus.req_sgn = 1'b0;
    check("s3 pend latched", 32'(bus.req_pend), 32'd1);
    wait_state("s3 MY", 3'd1, n);
    check("s3 MG length", 32'(n + 4), 32'(TMG));
    expect_phase("s3 MY", 3'd1, 6'b010_100, TY);
    check("s3 AR1 pend", 32'(bus.req_pend), 32'd1);
    expect_phase("s3 AR1", 3'd2, 6'b100_100, TAR);
    check("s3 CG pend", 32'(bus.req_pend), 32'd0);
    expect_phase("s3 CG", 3'd3, 6'b100_001, TCGMIN);
    expect_phase("s3 CY", 3'd4, 6'b100_010, TY);
    expect_phase("s3 AR2", 3'd5, 6'b100_100, TAR);

    // 4: flash requested at CG cycle 1
    bus.req_sgn = 1'b1;
    @(negedge clk);
    bus.req_sgn = 1'b0;
    wait_state("s4 CG", 3'd3, n);
    @(negedge clk);
    bus.flash_en = 1'b1;
    @(negedge clk);
    expect_phase("s4 CY", 3'd4, 6'b100_010, TY);
    expect_phase("s4 AR2", 3'd5, 6'b100_100, TAR);
    check("s4 FLASH state", 32'(bus.state_o), 32'd6);
    check("s4 blink0", 32'(bus.led), 32'h14);
    @(negedge clk);
    check("s4 blink1", 32'(bus.led), 32'h14);
    @(negedge clk);
    check("s4 blink2", 32'(bus.led), 32'h00);
    @(negedge clk);
    check("s4 blink3", 32'(bus.led), 32'h00);
    @(negedge clk);
    check("s4 blink4", 32'(bus.led), 32'h14);
    bus.flash_en = 1'b0;
    @(negedge clk);
    expect_phase("s4 exit AR2", 3'd5, 6'b100_100, TAR);
    check("s4 MG state", 32'(bus.state_o), 32'd0);

    // 5: flash at MG cycle 2 with a pending request
    bus.req_sgn = 1'b1;
    @(negedge clk);
    bus.req_sgn = 1'b0;
    @(negedge clk);
    check("s5 pend", 32'(bus.req_pend), 32'd1);
    bus.flash_en = 1'b1;
    @(negedge clk);
    expect_phase("s5 MY", 3'd1, 6'b010_100, TY);
    expect_phase("s5 AR1", 3'd2, 6'b100_100, TAR);
    check("s5 FLASH state", 32'(bus.state_o), 32'd6);
    check("s5 FLASH pend", 32'(bus.req_pend), 32'd0);
    bus.flash_en = 1'b0;
    @(negedge clk);
    expect_phase("s5 exit AR2", 3'd5, 6'b100_100, TAR);

    // 6: reset mid-MY
    bus.req_sgn = 1'b1;
    @(negedge clk);
    bus.req_sgn = 1'b0;
    wait_state("s6 MY", 3'd1, n);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("s6 rst pend", 32'(bus.req_pend), 32'd0);
    expect_phase("s6 AR2", 3'd5, 6'b100_100, TAR);
    check("s6 MG state", 32'(bus.state_o), 32'd0);

    // Randomized traffic, sticky flash mode, occasional reset
    for (int i = 0; i < 3000; i++) begin
      bus.req_sgn = ($urandom_range(3) == 0);
      if ($urandom_range(59) == 0) bus.flash_en = ~bus.flash_en;
      rst = ($urandom_range(499) == 0);
      @(negedge clk);
    end
    rst          = 1'b0;
    bus.flash_en = 1'b0;
    bus.req_sgn  = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
